// File: rtl/gf64_pow_seq_if.sv
// Request/response handshake bundle for the GF(2^6) power sequencer.
// master = requester/consumer side, slave = sequencer side.
interface gf64_pow_seq_if #(
    parameter int EXP_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_base;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_result;
    logic             busy;

    modport master (
        output in_valid, in_base, in_exp, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_base, in_exp, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/gf64_pow_seq.sv
// GF(2^6) exponentiation base^exp by left-to-right square-and-multiply,
// one shared combinational field multiplier, one multiply per clock.
module gf64_pow_seq #(
    parameter int         EXP_W   = 6,
    parameter logic [5:0] POLY_LO = 6'h03
) (
    input  logic          clk,
    input  logic          rst_n,
    gf64_pow_seq_if.slave bus
);
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_W - 1);

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t           state;
    logic [5:0]       acc;
    logic [5:0]       base_q;
    logic [EXP_W-1:0] exp_q;
    logic [IDX_W-1:0] idx;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [5:0]       result_q;
    logic [5:0]       mul_b;
    logic [5:0]       prod;

    // Carry-less product, then fold x^10..x^6 back down using x^6 = POLY_LO.
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] p;
        p = '0;
        for (int i = 0; i < 6; i++)
            if (b[i]) p = p ^ (11'(a) << i);
        for (int k = 10; k >= 6; k--)
            if (p[k]) begin
                p[k] = 1'b0;
                p    = p ^ (11'(POLY_LO) << (k - 6));
            end
        return p[5:0];
    endfunction

    assign mul_b = (state == MUL) ? base_q : acc;
    assign prod  = gf_mul(acc, mul_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            idx         <= IDX_LAST;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        base_q     <= bus.in_base;
                        exp_q      <= bus.in_exp;
                        acc        <= 6'h01;
                        idx        <= IDX_LAST;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= SQR;
                    end
                end
                SQR: begin
                    acc <= prod;
                    if (exp_q[idx]) begin
                        state <= MUL;
                    end else if (idx == '0) begin
                        result_q    <= prod;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                MUL: begin
                    acc <= prod;
                    if (idx == '0) begin
                        result_q    <= prod;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= SQR;
                    end
                end
                DONE: begin
                    // Result register is left as-is after the handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_gf64_pow_seq.sv
// Directed bench for gf64_pow_seq: latency, results, backpressure, reset abort.
module tb_gf64_pow_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [5:0] got;

    gf64_pow_seq_if #(.EXP_W(6)) bus ();

    gf64_pow_seq #(.EXP_W(6), .POLY_LO(6'h03)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-and-reduce (xtime) reference multiplier.
    function automatic logic [5:0] tb_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r;
        logic [5:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ t;
            t = t[5] ? ({t[4:0], 1'b0} ^ 6'h03) : {t[4:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [5:0] ref_pow(input logic [5:0] b, input int e);
        logic [5:0] r;
        r = 6'h01;
        for (int i = 0; i < e; i++) r = tb_mul(r, b);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic start(input logic [5:0] b, input logic [5:0] e);
        @(negedge clk);
        chk("ready_before_req", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_base  = b;
        bus.in_exp   = e;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_base  = ~b;
        bus.in_exp   = ~e;
    endtask

    // Counts edges after the accepting edge until out_valid; bounded at 40.
    task automatic wait_done(input string tag, input int lat, output logic [5:0] res);
        int   n;
        logic busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && n < 40) begin
            if (!bus.busy || bus.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
        res = bus.out_result;
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [5:0] b, input logic [5:0] e,
                       input int lat, input logic [5:0] res_exp);
        logic [5:0] r;
        start(b, e);
        wait_done(tag, lat, r);
        chk({tag, "_result"}, 32'(r), 32'(res_exp));
        handshake(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_base = '0;
        bus.in_exp = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);

        run("b2_e1", 6'h02, 6'd1, 7, 6'h02);
        run("b2_e6", 6'h02, 6'd6, 8, 6'h03);
        run("b2_e7", 6'h02, 6'd7, 9, 6'h06);

        start(6'h02, 6'd62);
        wait_done("inv2", 11, got);
        chk("inv2_result", 32'(got), 32'h21);
        chk("inv2_product", 32'(tb_mul(6'h02, got)), 32'h01);
        handshake("inv2");

        run("b0_e0", 6'h00, 6'd0, 6, 6'h01);
        run("b0_e5", 6'h00, 6'd5, 8, 6'h00);
        run("b15_e63", 6'h15, 6'd63, 12, 6'h01);
        run("b0_e63", 6'h00, 6'd63, 12, 6'h00);
        run("b1_e45", 6'h01, 6'd45, 10, 6'h01);
        run("b3_e2", 6'h03, 6'd2, 7, 6'h05);

        // Backpressure: hold result, ignore requests while DONE.
        start(6'h03, 6'd2);
        wait_done("bp", 7, got);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_base  = 6'(i + 9);
            bus.in_exp   = 6'd1;
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            chk("bp_result_hold", 32'(bus.out_result), 32'h05);
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        handshake("bp");
        chk("bp_idle_busy", 32'(bus.busy), 32'd0);
        chk("bp_result_kept", 32'(bus.out_result), 32'h05);

        // Reset during SQR of an inversion request.
        start(6'h02, 6'd62);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out_result", 32'(bus.out_result), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (15) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            chk("abort_no_result", 32'(seen), 32'd0);
        end
        run("after_abort", 6'h02, 6'd6, 8, 6'h03);

        // Inversion sweep over every nonzero element.
        for (int b = 1; b < 64; b++) begin
            start(6'(b), 6'd62);
            wait_done("sweep", 11, got);
            chk("sweep_inverse", 32'(tb_mul(6'(b), got)), 32'h01);
            chk("sweep_pow", 32'(got), 32'(ref_pow(6'(b), 62)));
            handshake("sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
